// File: rtl/wb_gpio_bank_pkg.sv
// wb_gpio_bank_pkg
//   Shared types for the wishbone GPIO bank: the bus handshake state,
//   the per-port register map (word index = wbs_adr_i[5:2]) and a helper
//   that expands wishbone byte selects into a 32-bit bit mask.
//   All registers reset to zero, so no separate reset-value constants exist.

package wb_gpio_bank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  // Word index within a port window (byte offset >> 2).
  typedef enum logic [3:0] {
    REG_IN       = 4'h0,
    REG_OUT      = 4'h1,
    REG_DIR      = 4'h2,
    REG_OUT_SET  = 4'h3,
    REG_OUT_CLR  = 4'h4,
    REG_OUT_TGL  = 4'h5,
    REG_RISE_EN  = 4'h6,
    REG_FALL_EN  = 4'h7,
    REG_STATUS   = 4'h8,
    REG_DEBOUNCE = 4'h9
  } reg_e;

  // One byte-lane select bit fans out to eight data bits.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_bank_if.sv
// wb_gpio_bank_if
//   Wishbone classic slave bundle as seen by the GPIO bank.
//   wbs_cyc_i / wbs_stb_i : cycle and strobe
//   wbs_we_i              : 1 = write
//   wbs_sel_i [3:0]       : byte lanes
//   wbs_adr_i [31:0]      : byte address
//   wbs_dat_i [31:0]      : write data
//   wbs_dat_o [31:0]      : read data, valid while wbs_ack_o is high
//   wbs_ack_o             : single-cycle acknowledge
//   Modports: master (bus initiator) and slave (the GPIO bank).

interface wb_gpio_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/wb_gpio_bank_pin_cond.sv
// wb_gpio_bank_pin_cond
//   Conditioning for one input pin: two-flop synchroniser, programmable
//   debounce and edge detection on the debounced value.
//   clk, rst         : clock, asynchronous active-high reset
//   pin_in           : raw pad input (asynchronous)
//   db_thresh        : debounce threshold in cycles, 0 = bypass
//   q                : debounced, stable pin value
//   rise / fall      : one-cycle pulses when q changes 0->1 / 1->0

module wb_gpio_bank_pin_cond #(
  parameter int DB_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pin_in,
  input  logic [DB_CNT_W-1:0] db_thresh,
  output logic                q,
  output logic                rise,
  output logic                fall
);

  logic                sync_a;
  logic                sync_b;
  logic                q_d;
  logic [DB_CNT_W-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with q and
  // restarts on any agreement, so a glitch shorter than the threshold never
  // reaches q. A threshold change deliberately leaves cnt alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      q      <= 1'b0;
      q_d    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= pin_in;
      sync_b <= sync_a;
      q_d    <= q;
      if (db_thresh == '0) begin
        q <= sync_b;
      end else if (sync_b == q) begin
        cnt <= '0;
      end else if (cnt + 1'b1 == db_thresh) begin
        q   <= sync_b;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank
//   Wishbone slave GPIO bank: NUM_PORTS ports of PORT_WIDTH pins each.
//   Every pin is synchronised, debounced and edge-detected; each port has
//   OUT/DIR registers with atomic set/clear/toggle, rise/fall interrupt
//   enables, a write-one-to-clear STATUS register and one level IRQ.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   bus                : wishbone slave (wb_gpio_bank_if.slave)
//   io_in              : pad inputs, port p = [p*PORT_WIDTH +: PORT_WIDTH]
//   io_out             : pad outputs (OUT registers)
//   io_oeb             : active-low output enables (~DIR)
//   irq                : per-port interrupt, OR of that port's STATUS

module wb_gpio_bank
  import wb_gpio_bank_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int PORT_WIDTH    = 8,
  parameter int DB_CNT_W      = 8,
  parameter int PORT_ADDR_LSB = 8
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  wb_gpio_bank_if.slave                   bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] io_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] io_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] io_oeb,
  output logic [NUM_PORTS-1:0]            irq
);

  bus_state_e state;

  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] out_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] dir_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] rise_en_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] fall_en_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] status_q;
  logic [NUM_PORTS-1:0][DB_CNT_W-1:0]   debounce_q;

  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] pin_q;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] rise_v;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] fall_v;

  logic [3:0]            port_idx;
  reg_e                  reg_sel;
  logic [NUM_PORTS-1:0]  port_hit;
  logic                  req;
  logic                  fire;
  logic                  wr_fire;
  logic [31:0]           byte_mask;
  logic [PORT_WIDTH-1:0] wr_mask;
  logic [PORT_WIDTH-1:0] wr_bits;
  logic [DB_CNT_W-1:0]   db_mask;
  logic [DB_CNT_W-1:0]   db_bits;
  logic [31:0]           rd_data;
  logic                  unused_bits;

  assign port_idx = bus.wbs_adr_i[PORT_ADDR_LSB +: 4];
  assign reg_sel  = reg_e'(bus.wbs_adr_i[5:2]);

  // Address bits outside the port/register fields and data bits above the
  // register width carry no meaning here.
  assign unused_bits = ^{bus.wbs_adr_i, bus.wbs_dat_i, byte_mask};

  // An out-of-range port index matches no port, so it reads 0 and its
  // writes fall on the floor while the access is still acknowledged.
  always_comb begin
    port_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_hit[p] = (port_idx == 4'(p));
    end
  end

  assign req     = bus.wbs_cyc_i & bus.wbs_stb_i & ~bus.wbs_ack_o;
  assign fire    = (state == ST_IDLE) & req;
  assign wr_fire = fire & bus.wbs_we_i;

  assign byte_mask = sel_to_mask(bus.wbs_sel_i);
  assign wr_mask   = byte_mask[PORT_WIDTH-1:0];
  assign wr_bits   = bus.wbs_dat_i[PORT_WIDTH-1:0] & wr_mask;
  assign db_mask   = byte_mask[DB_CNT_W-1:0];
  assign db_bits   = bus.wbs_dat_i[DB_CNT_W-1:0] & db_mask;

  // Pin conditioning, one instance per pin.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar b = 0; b < PORT_WIDTH; b++) begin : g_pin
      wb_gpio_bank_pin_cond #(
        .DB_CNT_W(DB_CNT_W)
      ) u_pin (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .pin_in   (io_in[p*PORT_WIDTH + b]),
        .db_thresh(debounce_q[p]),
        .q        (pin_q[p][b]),
        .rise     (rise_v[p][b]),
        .fall     (fall_v[p][b])
      );
    end
  end

  // Read mux. IN returns the debounced value regardless of DIR; write-only
  // and unmapped registers fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p]) begin
        case (reg_sel)
          REG_IN:       rd_data = 32'(pin_q[p]);
          REG_OUT:      rd_data = 32'(out_q[p]);
          REG_DIR:      rd_data = 32'(dir_q[p]);
          REG_RISE_EN:  rd_data = 32'(rise_en_q[p]);
          REG_FALL_EN:  rd_data = 32'(fall_en_q[p]);
          REG_STATUS:   rd_data = 32'(status_q[p]);
          REG_DEBOUNCE: rd_data = 32'(debounce_q[p]);
          default:      rd_data = '0;
        endcase
      end
    end
  end

  // Bus handshake: a request seen in IDLE is acknowledged on the next cycle
  // for exactly one cycle; returning through IDLE guarantees a gap between
  // consecutive acks. Read data is captured together with ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            state         <= ST_ACK;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.wbs_we_i ? 32'h0 : rd_data;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register file. Writes commit on the edge that raises ack. STATUS is
  // cleared by the masked W1C bits and then OR-ed with new edge events, so
  // a hardware set in the same cycle as a clear keeps the bit set.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q      <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      debounce_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        status_q[p] <= (status_q[p] &
                        ~((wr_fire && port_hit[p] && reg_sel == REG_STATUS) ? wr_bits : '0))
                       | (rise_v[p] & rise_en_q[p])
                       | (fall_v[p] & fall_en_q[p]);
        if (wr_fire && port_hit[p]) begin
          case (reg_sel)
            REG_OUT:      out_q[p]      <= (out_q[p] & ~wr_mask) | wr_bits;
            REG_DIR:      dir_q[p]      <= (dir_q[p] & ~wr_mask) | wr_bits;
            REG_OUT_SET:  out_q[p]      <= out_q[p] | wr_bits;
            REG_OUT_CLR:  out_q[p]      <= out_q[p] & ~wr_bits;
            REG_OUT_TGL:  out_q[p]      <= out_q[p] ^ wr_bits;
            REG_RISE_EN:  rise_en_q[p]  <= (rise_en_q[p] & ~wr_mask) | wr_bits;
            REG_FALL_EN:  fall_en_q[p]  <= (fall_en_q[p] & ~wr_mask) | wr_bits;
            REG_DEBOUNCE: debounce_q[p] <= (debounce_q[p] & ~db_mask) | db_bits;
            default:      ;
          endcase
        end
      end
    end
  end

  assign io_out = out_q;
  assign io_oeb = ~dir_q;

  always_comb begin
    irq = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irq[p] = |status_q[p];
    end
  end

endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb_wb_gpio_bank
//   Directed bench for wb_gpio_bank (2 ports x 8 pins, 8-bit debounce).
//   Bus accesses push their expected response into a scoreboard queue; an
//   independent monitor pops and compares whenever ack is presented. Pad
//   outputs and irq are compared directly by the stimulus process.

module tb_wb_gpio_bank;

  localparam int NP = 2;
  localparam int PW = 8;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic [NP*PW-1:0] io_in    = '0;
  logic [NP*PW-1:0] io_out;
  logic [NP*PW-1:0] io_oeb;
  logic [NP-1:0]    irq;

  wb_gpio_bank_if bus ();

  wb_gpio_bank #(
    .NUM_PORTS    (NP),
    .PORT_WIDTH   (PW),
    .DB_CNT_W     (8),
    .PORT_ADDR_LSB(8)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus.slave),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oeb  (io_oeb),
    .irq     (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads compare data.
  always @(negedge wb_clk_i) begin
    if (bus.wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack actual=1 required=0");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_read) check_output(mon_e.name, bus.wbs_dat_o, mon_e.data);
      end
    end
  end

  // One bus access: ack must arrive exactly one cycle after stb and last one cycle.
  task automatic apply_stimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] exp_data,
                                input string name);
    exp_t e;
    int   n;
    @(negedge wb_clk_i);
    e.is_read = !we;
    e.data    = exp_data;
    e.name    = name;
    sb_q.push_back(e);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 20);
    check_output({name, "_ack_latency"}, 32'(n), 32'd1);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    check_output({name, "_ack_width"}, 32'(bus.wbs_ack_o), 32'd0);
  endtask

  function automatic logic [31:0] reg_adr(input int port, input int reg_idx);
    return (32'(port) << 8) | (32'(reg_idx) << 2);
  endfunction

  task automatic wr(input int port, input int reg_idx, input logic [31:0] dat,
                    input logic [3:0] sel, input string name);
    apply_stimulus(1'b1, reg_adr(port, reg_idx), dat, sel, 32'h0, name);
  endtask

  task automatic rd(input int port, input int reg_idx, input logic [31:0] exp_data,
                    input string name);
    apply_stimulus(1'b0, reg_adr(port, reg_idx), 32'h0, 4'hF, exp_data, name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rw_regs[6];
    rw_regs = '{1, 2, 6, 7, 8, 9};
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_output("rst_io_oeb", 32'(io_oeb), 32'h0000_FFFF);
    check_output("rst_io_out", 32'(io_out), 32'h0);
    check_output("rst_irq", 32'(irq), 32'h0);
    for (int p = 0; p < NP; p++) begin
      for (int r = 0; r < 6; r++) begin
        rd(p, rw_regs[r], 32'h0, $sformatf("rst_p%0d_r%0d", p, rw_regs[r]));
      end
    end

    // Port1 output path: A5 | 02 = A7, & ~80 = 27, ^ 0F = 28
    wr(1, 2, 32'hFF, 4'hF, "p1_dir");
    wr(1, 1, 32'hA5, 4'hF, "p1_out");
    wr(1, 3, 32'h02, 4'hF, "p1_set");
    wr(1, 4, 32'h80, 4'hF, "p1_clr");
    wr(1, 5, 32'h0F, 4'hF, "p1_tgl");
    check_output("p1_io_out", 32'(io_out), 32'h0000_2800);
    check_output("p1_io_oeb", 32'(io_oeb), 32'h0000_00FF);
    rd(1, 1, 32'h28, "p1_out_rb");
    rd(1, 2, 32'hFF, "p1_dir_rb");
    rd(1, 3, 32'h0, "p1_set_wo");
    rd(1, 0, 32'h0, "p1_in");

    // Debounce: a 3-cycle pulse is filtered with threshold 4
    wr(0, 9, 32'h4, 4'hF, "p0_db");
    rd(0, 9, 32'h4, "p0_db_rb");
    @(negedge wb_clk_i);
    io_in[0] = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    io_in[0] = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    rd(0, 0, 32'h0, "p0_in_glitch");
    rd(0, 8, 32'h0, "p0_status_glitch");
    @(negedge wb_clk_i);
    io_in[0] = 1'b1;
    rd(0, 0, 32'h0, "p0_in_early");
    repeat (10) @(negedge wb_clk_i);
    rd(0, 0, 32'h1, "p0_in_stable");

    // Edge capture: past rise is not flagged, the fall is
    wr(0, 6, 32'h1, 4'hF, "p0_rise_en");
    wr(0, 7, 32'h1, 4'hF, "p0_fall_en");
    rd(0, 8, 32'h0, "p0_status_no_retro");
    io_in[0] = 1'b0;
    repeat (12) @(negedge wb_clk_i);
    rd(0, 8, 32'h1, "p0_status_fall");
    check_output("irq_fall", 32'(irq), 32'h1);
    wr(0, 8, 32'h1, 4'hF, "p0_w1c");
    check_output("irq_cleared", 32'(irq), 32'h0);
    rd(0, 8, 32'h0, "p0_status_cleared");

    // W1C committing on the same edge as a hardware set: set wins
    wr(0, 9, 32'h0, 4'hF, "p0_db_off");
    repeat (4) @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    io_in[0] = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wr(0, 8, 32'h1, 4'hF, "p0_w1c_race");
    rd(0, 8, 32'h1, "p0_status_race");
    check_output("irq_race", 32'(irq), 32'h1);

    // Byte-lane masking, out-of-range port, unmapped register
    wr(0, 1, 32'hFFFF_FFFF, 4'b0010, "p0_out_lane1");
    rd(0, 1, 32'h0, "p0_out_lane1_rb");
    wr(0, 1, 32'hFFFF_FF3C, 4'b0001, "p0_out_lane0");
    rd(0, 1, 32'h3C, "p0_out_lane0_rb");
    check_output("lane_io_out", 32'(io_out), 32'h0000_283C);
    wr(0, 3, 32'hFF, 4'b0010, "p0_set_lane1");
    check_output("set_lane1_io_out", 32'(io_out), 32'h0000_283C);
    rd(5, 1, 32'h0, "p5_out_rd");
    wr(5, 1, 32'hFF, 4'hF, "p5_out_wr");
    check_output("p5_io_out", 32'(io_out), 32'h0000_283C);
    rd(0, 10, 32'h0, "p0_unmapped");
    rd(0, 5, 32'h0, "p0_tgl_wo");
    wr(0, 2, 32'hFFFF_FFFF, 4'hF, "p0_dir_all");
    rd(0, 2, 32'hFF, "p0_dir_width");
    check_output("p0_io_oeb", 32'(io_oeb), 32'h0);

    // Reset while an ack is pending
    @(negedge wb_clk_i);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = reg_adr(0, 1);
    bus.wbs_dat_i = 32'h55;
    bus.wbs_sel_i = 4'hF;
    #2 wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_output("rst_pending_ack0", 32'(bus.wbs_ack_o), 32'h0);
    @(negedge wb_clk_i);
    check_output("rst_pending_ack1", 32'(bus.wbs_ack_o), 32'h0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_output("rst2_io_out", 32'(io_out), 32'h0);
    check_output("rst2_io_oeb", 32'(io_oeb), 32'h0000_FFFF);
    wr(0, 1, 32'h11, 4'hF, "post_rst_out");
    rd(0, 1, 32'h11, "post_rst_out_rb");
    check_output("post_rst_io_out", 32'(io_out), 32'h0000_0011);

    repeat (3) @(negedge wb_clk_i);
    check_output("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
